frame_rx_proc: RTL and testbench

//  Receive-side frame processor, the counterpart to the transmit frame FSM. It takes the
//  16-bit word stream from the link decoder and locates SOP / 3x preamble / SOF / data / CRC / EOP.
//  It strips the framing, delivers the payload words, and checks the CRC-16 over the payload.

---
 rtl/frame_pkg.sv | 34 +++
 rtl/crc16_d16.sv | 30 +++
 rtl/frame_rx_proc.sv | 195 +++++++++++++++++++
 tb/tb_frame_rx_proc.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared framing constants, receive FSM state encoding and the CRC-16-CCITT step
// used by both the transmit and receive frame paths.
package frame_pkg;

  localparam logic [15:0] SOP_WORD      = 16'h50BC;
  localparam logic [15:0] PREAMBLE_WORD = 16'h5555;
  localparam logic [15:0] SOF_WORD      = 16'hD5D5;
  localparam logic [15:0] EOP_WORD      = 16'hFDBC;
  localparam int          PRE_LEN       = 3;
  localparam logic [15:0] CRC_POLY      = 16'h1021;
  localparam logic [15:0] CRC_INIT      = 16'hFFFF;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PRE      = 4'd1,
    ST_WAIT_SOF = 4'd2,
    ST_DATA     = 4'd3,
    ST_EOP      = 4'd4
  } rx_state_e;

  // One 16-bit word folded into the CRC, MSB first, no reflection.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [15:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_d16.sv
// Word-parallel CRC-16-CCITT register: CLR reloads the seed, DV folds in one 16-bit word.
module crc16_d16
  import frame_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        CLR,
  input  logic        DV,
  input  logic [15:0] D,
  output logic [15:0] CRC
);

  logic [15:0] crc_q, crc_d;

  // NOTE: every signal written here gets its default first, so no path leaves it unassigned (no latch).
  always_comb begin
    crc_d = crc_q;
    if (CLR)     crc_d = CRC_INIT;
    else if (DV) crc_d = crc16_next(crc_q, D);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) crc_q <= CRC_INIT;
    else      crc_q <= crc_d;
  end

  assign CRC = crc_q;

endmodule

// File: rtl/frame_rx_proc.sv
// Receive frame processor: strips SOP/preamble/SOF/EOP framing, delivers payload words
// through a one-word hold register and checks the trailing CRC-16 word.
module frame_rx_proc
  import frame_pkg::*;
#(
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W     = 11
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [15:0]      RXD,
  input  logic             RX_K,
  input  logic             RX_VALID,
  output logic [15:0]      DOUT,
  output logic             DOUT_VLD,
  output logic             SOF_DET,
  output logic             FRM_DONE,
  output logic             CRC_ERR,
  output logic             FRM_ERR,
  output logic [CNT_W-1:0] WORD_CNT,
  output logic [3:0]       RX_FRM_STATE
);

  rx_state_e        state_q, state_d;
  logic [1:0]       pre_cnt_q, pre_cnt_d;
  logic [15:0]      hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [15:0]      dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             sof_det_q, sof_det_d;
  logic             frm_done_q, frm_done_d;
  logic             crc_err_q, crc_err_d;
  logic             frm_err_q, frm_err_d;

  logic             crc_clr, crc_dv;
  logic [15:0]      crc_val;

  logic is_sop, is_eop, is_pre, is_sof;
  assign is_sop = RX_K  && (RXD == SOP_WORD);
  assign is_eop = RX_K  && (RXD == EOP_WORD);
  assign is_pre = !RX_K && (RXD == PREAMBLE_WORD);
  assign is_sof = !RX_K && (RXD == SOF_WORD);

  // The CRC only ever sees words released from the hold register, never the CRC word itself.
  crc16_d16 u_crc (
    .CLK (CLK),
    .RST (RST),
    .CLR (crc_clr),
    .DV  (crc_dv),
    .D   (hold_q),
    .CRC (crc_val)
  );

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    word_cnt_d  = word_cnt_q;
    dout_d      = dout_q;
    dout_vld_d  = 1'b0;
    sof_det_d   = 1'b0;
    frm_done_d  = 1'b0;
    crc_err_d   = 1'b0;
    frm_err_d   = 1'b0;
    crc_clr     = 1'b0;
    crc_dv      = 1'b0;

    if (RX_VALID) begin
      unique case (state_q)
        ST_IDLE: begin
          if (is_sop) begin
            state_d   = ST_PRE;
            pre_cnt_d = '0;
          end
        end

        ST_PRE: begin
          if (is_pre) begin
            if (pre_cnt_q == 2'(PRE_LEN - 1)) begin
              state_d   = ST_WAIT_SOF;
              pre_cnt_d = '0;
            end else begin
              pre_cnt_d = pre_cnt_q + 2'd1;
            end
          end else begin
            frm_err_d = 1'b1;
            state_d   = is_sop ? ST_PRE : ST_IDLE;
            pre_cnt_d = '0;
          end
        end

        ST_WAIT_SOF: begin
          if (is_sof) begin
            sof_det_d   = 1'b1;
            crc_clr     = 1'b1;
            word_cnt_d  = '0;
            hold_full_d = 1'b0;
            state_d     = ST_DATA;
          end else begin
            frm_err_d = 1'b1;
            state_d   = is_sop ? ST_PRE : ST_IDLE;
            pre_cnt_d = '0;
          end
        end

        ST_DATA: begin
          if (!RX_K) begin
            if (hold_full_q && (word_cnt_q == CNT_W'(MAX_WORDS))) begin
              // Releasing the held word would exceed the length limit: abort without output.
              frm_err_d   = 1'b1;
              hold_full_d = 1'b0;
              state_d     = ST_IDLE;
            end else begin
              hold_d      = RXD;
              hold_full_d = 1'b1;
              if (hold_full_q) begin
                dout_d     = hold_q;
                dout_vld_d = 1'b1;
                crc_dv     = 1'b1;
                word_cnt_d = word_cnt_q + CNT_W'(1);
              end
            end
          end else if (is_eop) begin
            hold_full_d = 1'b0;
            if (word_cnt_q == '0) begin
              frm_err_d = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              frm_done_d = 1'b1;
              crc_err_d  = (hold_q != crc_val);
              state_d    = ST_EOP;
            end
          end else begin
            frm_err_d   = 1'b1;
            hold_full_d = 1'b0;
            pre_cnt_d   = '0;
            state_d     = is_sop ? ST_PRE : ST_IDLE;
          end
        end

        ST_EOP: begin
          if (is_sop) begin
            state_d   = ST_PRE;
            pre_cnt_d = '0;
          end else if (!is_eop) begin
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: the one-word hold register is reset along with the control state so DOUT and the CRC input never carry X.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      pre_cnt_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      word_cnt_q  <= '0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      sof_det_q   <= 1'b0;
      frm_done_q  <= 1'b0;
      crc_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      word_cnt_q  <= word_cnt_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      sof_det_q   <= sof_det_d;
      frm_done_q  <= frm_done_d;
      crc_err_q   <= crc_err_d;
      frm_err_q   <= frm_err_d;
    end
  end

  assign DOUT         = dout_q;
  assign DOUT_VLD     = dout_vld_q;
  assign SOF_DET      = sof_det_q;
  assign FRM_DONE     = frm_done_q;
  assign CRC_ERR      = crc_err_q;
  assign FRM_ERR      = frm_err_q;
  assign WORD_CNT     = word_cnt_q;
  assign RX_FRM_STATE = state_q;

endmodule

// File: tb/tb_frame_rx_proc.sv
// Self-checking bench for frame_rx_proc: directed and random frames compared against
// expectations derived from the payload lists and a bit-serial CRC reference.
module tb_frame_rx_proc;
  import frame_pkg::*;

  localparam int MAX_WORDS = 1024;
  localparam int CNT_W     = 11;

  logic             CLK = 1'b0;
  logic             RST;
  logic [15:0]      RXD;
  logic             RX_K;
  logic             RX_VALID;
  logic [15:0]      DOUT;
  logic             DOUT_VLD;
  logic             SOF_DET;
  logic             FRM_DONE;
  logic             CRC_ERR;
  logic             FRM_ERR;
  logic [CNT_W-1:0] WORD_CNT;
  logic [3:0]       RX_FRM_STATE;

  frame_rx_proc #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RXD          (RXD),
    .RX_K         (RX_K),
    .RX_VALID     (RX_VALID),
    .DOUT         (DOUT),
    .DOUT_VLD     (DOUT_VLD),
    .SOF_DET      (SOF_DET),
    .FRM_DONE     (FRM_DONE),
    .CRC_ERR      (CRC_ERR),
    .FRM_ERR      (FRM_ERR),
    .WORD_CNT     (WORD_CNT),
    .RX_FRM_STATE (RX_FRM_STATE)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int gap_mode = 0;   // 0: back-to-back, 1: valid toggles every cycle, 2: random idle gaps

  logic [15:0] pay[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  int               n_sof, n_done, n_err, n_vld, n_overlap, n_consec;
  logic             last_crc_err;
  logic [CNT_W-1:0] last_cnt;
  logic             vld_prev;

  always @(negedge CLK) begin
    if (DOUT_VLD) begin
      got_q.push_back(DOUT);
      n_vld++;
      if (vld_prev) n_consec++;
    end
    vld_prev = DOUT_VLD;
    if (SOF_DET) n_sof++;
    if (FRM_DONE) begin
      n_done++;
      last_crc_err = CRC_ERR;
      last_cnt     = WORD_CNT;
    end
    if (FRM_ERR) n_err++;
    if (FRM_DONE && FRM_ERR) n_overlap++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bit-serial CCITT reference over the current payload list.
  function automatic logic [15:0] ref_crc();
    logic [15:0] c = 16'hFFFF;
    for (int w = 0; w < pay.size(); w++)
      for (int b = 15; b >= 0; b--) begin
        logic msb = c[15];
        c = c << 1;
        if (msb ^ pay[w][b]) c = c ^ 16'h1021;
      end
    return c;
  endfunction

  task automatic send(input logic k, input logic [15:0] d);
    int idle;
    RXD = d; RX_K = k; RX_VALID = 1'b1;
    @(posedge CLK); #1;
    RX_VALID = 1'b0; RXD = 16'($urandom); RX_K = 1'($urandom);
    idle = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
    repeat (idle) begin @(posedge CLK); #1; end
  endtask

  task automatic send_body(input logic [15:0] crc_xor, input int n_eop);
    for (int i = 0; i < PRE_LEN; i++) send(1'b0, PREAMBLE_WORD);
    send(1'b0, SOF_WORD);
    foreach (pay[i]) send(1'b0, pay[i]);
    send(1'b0, ref_crc() ^ crc_xor);
    repeat (n_eop) send(1'b1, EOP_WORD);
  endtask

  task automatic send_frame(input logic [15:0] crc_xor, input int n_eop);
    send(1'b1, SOP_WORD);
    send_body(crc_xor, n_eop);
  endtask

  task automatic fill_pay(input int n, input bit random_data);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(random_data ? 16'($urandom) : 16'(i + 1));
  endtask

  task automatic clear_mon();
    got_q.delete(); exp_q.delete();
    n_sof = 0; n_done = 0; n_err = 0; n_vld = 0; n_overlap = 0; n_consec = 0;
    last_crc_err = 1'b0; last_cnt = '0;
  endtask

  task automatic settle();
    repeat (4) begin @(posedge CLK); #1; end
  endtask

  task automatic check_frame(input string tag, input int e_sof, input int e_done, input int e_err,
                             input logic e_crc_err, input int e_cnt);
    check({tag, "_sof"},     n_sof, e_sof);
    check({tag, "_done"},    n_done, e_done);
    check({tag, "_err"},     n_err, e_err);
    check({tag, "_overlap"}, n_overlap, 0);
    if (e_done > 0) begin
      check({tag, "_crc_err"}, last_crc_err, e_crc_err);
      check({tag, "_cnt"},     last_cnt, e_cnt);
    end
    check({tag, "_nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) check($sformatf("%s_dout%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] saved[$];
    RST = 1'b0; RXD = '0; RX_K = 1'b0; RX_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", {DOUT, DOUT_VLD, SOF_DET, FRM_DONE, CRC_ERR, FRM_ERR, WORD_CNT, RX_FRM_STATE}, 64'd0);
    RST = 1'b1;
    settle();

    // Basic frame with payload 1..4 and three EOPs.
    gap_mode = 0; clear_mon(); fill_pay(4, 0);
    send_frame(16'h0000, 3); settle();
    exp_q = pay;
    check_frame("t1", 1, 1, 0, 1'b0, 4);
    check("t1_cnt_hold", WORD_CNT, 4);
    check("t1_state", RX_FRM_STATE, 4);

    // Corrupted CRC bit 0.
    clear_mon();
    send_frame(16'h0001, 3); settle();
    exp_q = pay;
    check_frame("t2", 1, 1, 0, 1'b1, 4);

    // RX_VALID toggling every cycle.
    gap_mode = 1; clear_mon();
    send_frame(16'h0000, 3); settle();
    exp_q = pay;
    check_frame("t3", 1, 1, 0, 1'b0, 4);
    check("t3_consec_vld", n_consec, 0);
    gap_mode = 0;

    // Bad 2nd preamble word, then a good frame.
    clear_mon(); fill_pay(5, 1);
    send(1'b1, SOP_WORD); send(1'b0, PREAMBLE_WORD); send(1'b0, 16'h5554);
    check("t4a_state_after_err", RX_FRM_STATE, 0);
    send_frame(16'h0000, 1); settle();
    exp_q = pay;
    check_frame("t4a", 1, 1, 1, 1'b0, 5);

    // SOP injected mid-Data resyncs straight into the next frame.
    clear_mon(); fill_pay(3, 1); saved = pay;
    send(1'b1, SOP_WORD);
    for (int i = 0; i < PRE_LEN; i++) send(1'b0, PREAMBLE_WORD);
    send(1'b0, SOF_WORD);
    foreach (saved[i]) send(1'b0, saved[i]);
    fill_pay(4, 1);
    send(1'b1, SOP_WORD);
    check("t4b_resync_state", RX_FRM_STATE, 1);
    send_body(16'h0000, 2); settle();
    exp_q.push_back(saved[0]); exp_q.push_back(saved[1]);
    foreach (pay[i]) exp_q.push_back(pay[i]);
    check_frame("t4b", 2, 1, 1, 1'b0, 4);

    // Exactly MAX_WORDS payload words.
    clear_mon(); fill_pay(MAX_WORDS, 1);
    send_frame(16'h0000, 1); settle();
    exp_q = pay;
    check_frame("t5a", 1, 1, 0, 1'b0, MAX_WORDS);

    // One word over the limit.
    clear_mon(); fill_pay(MAX_WORDS + 1, 1);
    send_frame(16'h0000, 1); settle();
    for (int i = 0; i < MAX_WORDS; i++) exp_q.push_back(pay[i]);
    check_frame("t5b", 1, 0, 1, 1'b0, 0);
    check("t5b_vld_count", n_vld, MAX_WORDS);

    // Reset mid-frame after two payload words.
    clear_mon(); fill_pay(5, 1); pay[0] = pay[0] | 16'h0001;
    send(1'b1, SOP_WORD);
    for (int i = 0; i < PRE_LEN; i++) send(1'b0, PREAMBLE_WORD);
    send(1'b0, SOF_WORD);
    send(1'b0, pay[0]); send(1'b0, pay[1]);
    check("t6_pre_reset_cnt", WORD_CNT, 1);
    check("t6_pre_reset_dout", DOUT, pay[0]);
    RST = 1'b0; #1;
    check("t6_reset_outputs", {DOUT, DOUT_VLD, SOF_DET, FRM_DONE, CRC_ERR, FRM_ERR, WORD_CNT, RX_FRM_STATE}, 64'd0);
    repeat (2) @(posedge CLK);
    #1; RST = 1'b1;
    send(1'b0, pay[2]); send(1'b0, ref_crc()); send(1'b1, EOP_WORD); settle();
    check_frame("t6_abort", 1, 0, 0, 1'b0, 0);
    clear_mon(); fill_pay(6, 1);
    send_frame(16'h0000, 2); settle();
    exp_q = pay;
    check_frame("t6_next", 1, 1, 0, 1'b0, 6);

    // Too-short frames: CRC only, and EOP straight after SOF.
    clear_mon(); fill_pay(0, 1);
    send_frame(16'h0000, 1);
    send(1'b1, SOP_WORD);
    for (int i = 0; i < PRE_LEN; i++) send(1'b0, PREAMBLE_WORD);
    send(1'b0, SOF_WORD); send(1'b1, EOP_WORD); settle();
    check_frame("t7_short", 2, 0, 2, 1'b0, 0);

    // Random frames with random gaps, lengths, CRC corruption and EOP repeats.
    gap_mode = 2;
    for (int f = 0; f < 8; f++) begin
      logic [15:0] cx;
      int n;
      n  = $urandom_range(1, 24);
      cx = ($urandom_range(0, 1) == 1) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
      clear_mon(); fill_pay(n, 1);
      send_frame(cx, $urandom_range(1, 3)); settle();
      exp_q = pay;
      check_frame($sformatf("rnd%0d", f), 1, 1, 0, (cx != 16'h0000), n);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
